// File: rtl/sw_word_loader_if.sv
// Operator-side bus of the switch word loader: switch/button inputs and the
// committed register-file write plus the progress LEDs.
interface sw_word_loader_if;
  logic [7:0]  SW;
  logic        Load_BTN;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic [7:0]  LED;

  // Board / bench side: drives switches and button, watches the write port.
  modport master (
    output SW, Load_BTN,
    input  W_Addr, W_Data, Write_Reg, LED
  );

  // Loader side.
  modport slave (
    input  SW, Load_BTN,
    output W_Addr, W_Data, Write_Reg, LED
  );
endinterface

// File: rtl/sw_word_loader.sv
// Hand-entry of one register-file write: address byte, then four data bytes
// (little-endian) taken from the slide switches on each debounced button
// press, followed by a single-cycle write strobe.
module sw_word_loader #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  sw_word_loader_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_B0    = 3'd1,
    S_B1    = 3'd2,
    S_B2    = 3'd3,
    S_B3    = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;

  logic [1:0]    sync_q;
  logic          btn_s;
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] db_cnt;
  logic          press;

  state_t        state_q, state_d;
  word_t         pend_q;
  word_t         wr_q;
  logic          write_q;
  logic [7:0]    led_q;

  logic          ld_addr;
  logic [3:0]    ld_byte;
  logic          commit;

  assign btn_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_100MHz) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.Load_BTN};
  end

  // Debouncer: level only follows btn_s after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Previous debounced level, for rising-edge detection.
  always_ff @(posedge clk_100MHz) begin
    if (rst) btn_db_q <= 1'b0;
    else     btn_db_q <= btn_db;
  end

  assign press = btn_db & ~btn_db_q;

  // FSM state register.
  always_ff @(posedge clk_100MHz) begin
    if (rst) state_q <= S_ADDR;
    else     state_q <= state_d;
  end

  // Next state and per-phase load enables; illegal codes fall back to S_ADDR.
  always_comb begin
    state_d = state_q;
    ld_addr = 1'b0;
    ld_byte = 4'b0000;
    commit  = 1'b0;
    case (state_q)
      S_ADDR:  if (press) begin ld_addr = 1'b1;    state_d = S_B0;    end
      S_B0:    if (press) begin ld_byte[0] = 1'b1; state_d = S_B1;    end
      S_B1:    if (press) begin ld_byte[1] = 1'b1; state_d = S_B2;    end
      S_B2:    if (press) begin ld_byte[2] = 1'b1; state_d = S_B3;    end
      S_B3:    if (press) begin
                 ld_byte[3] = 1'b1;
                 commit     = 1'b1;
                 state_d    = S_WRITE;
               end
      S_WRITE: state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

  // Pending address/word being assembled from the switches.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      if (ld_addr)    pend_q.addr         <= bus.SW[4:0];
      if (ld_byte[0]) pend_q.data[7:0]    <= bus.SW;
      if (ld_byte[1]) pend_q.data[15:8]   <= bus.SW;
      if (ld_byte[2]) pend_q.data[23:16]  <= bus.SW;
      if (ld_byte[3]) pend_q.data[31:24]  <= bus.SW;
    end
  end

  // Committed word and strobe: loaded on the edge that enters S_WRITE so the
  // new values and Write_Reg are visible together for that one cycle. The
  // top byte is taken straight from the switches since it arrives with the
  // same press.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      wr_q    <= '0;
      write_q <= 1'b0;
    end else begin
      write_q <= commit;
      if (commit) begin
        wr_q.addr <= pend_q.addr;
        wr_q.data <= {bus.SW, pend_q.data[23:0]};
      end
    end
  end

  // Progress display, one cycle behind state and address.
  always_ff @(posedge clk_100MHz) begin
    if (rst) led_q <= 8'h00;
    else     led_q <= {state_q, wr_q.addr};
  end

  assign bus.W_Addr    = wr_q.addr;
  assign bus.W_Data    = wr_q.data;
  assign bus.Write_Reg = write_q;
  assign bus.LED       = led_q;

endmodule

// File: doc/sw_word_loader.md
# sw_word_loader

Operator-input block for the R-type CPU board: loads a register-file address and a 32-bit data word entered from the 8 slide switches, one byte per press of a debounced load button. The committed address/word is then presented to the CPU register file as a one-cycle write strobe. It is the write-side counterpart to the byte-selectable LED result display, so register contents can be set by hand before single-stepping.

## Interface

**Parameters**
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to change the debounced button level (10 ms at 100 MHz; benches use 4).

**Ports**
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous and active-high.
- SW  in  8  data byte in byte phases; SW[4:0] is the address in the address phase, and SW[7:5] is ignored there.
- Load_BTN  in  1  raw, bouncing, asynchronous push button.
- W_Addr  out  5  committed register address.
- W_Data  out  32  committed data word.
- Write_Reg  out  1  one-cycle write strobe to the register file, clocked by clk_100MHz.
- LED  out  8  progress display: LED[7:5] = FSM state code, LED[4:0] = W_Addr.

## Operation

**Button path**
- Load_BTN passes through a 2-flop synchronizer, giving btn_s.
- Debouncer state: a level btn_db and a counter.
  - When btn_s equals btn_db, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, btn_db takes btn_s and the counter clears.
- press is a one-cycle pulse on the btn_db 0→1 transition. Releases produce nothing.

**FSM** (state codes in brackets)
- S_ADDR [0]: on press, latch SW[4:0] into the pending address and go to S_B0.
- S_B0 [1]: on press, pending[7:0] = SW, go to S_B1.
- S_B1 [2]: on press, pending[15:8] = SW, go to S_B2.
- S_B2 [3]: on press, pending[23:16] = SW, go to S_B3.
- S_B3 [4]: on press, pending[31:24] = SW, go to S_WRITE.
- S_WRITE [5]: for exactly one cycle, W_Addr/W_Data load the pending values and Write_Reg = 1. Then go unconditionally to S_ADDR.
- Codes 6 and 7 are unreachable. If entered, the FSM returns to S_ADDR on the next cycle with no write.

**Data rules**
- Byte order is little-endian: the first data byte is W_Data[7:0].
- W_Addr and W_Data change only in the S_WRITE cycle and hold between writes.
- Address 0 is written like any other address; discarding it is the register file's responsibility.
- A press arriving in the S_WRITE cycle is impossible, because the debouncer guarantees at least DEBOUNCE_CYCLES between presses. It needs no handling.

## Timing

**Reset values**
- FSM = S_ADDR; pending address/data = 0; W_Addr = 0; W_Data = 0; Write_Reg = 0; LED = 8'h00.
- Synchronizer flops = 0; btn_db = 0; counter = 0.

**Press latency**
- From a clean Load_BTN rise to press high is 2 + DEBOUNCE_CYCLES cycles.
- SW is sampled in the press cycle and must be stable in that cycle. SW is not synchronized.

**Write latency**
- Write_Reg rises in the cycle after the press that captured byte 3.
- W_Addr/W_Data show their new values in the same cycle Write_Reg is high.

**Bounce behaviour**
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- One long hold produces exactly one press.

**Reset mid-operation**
- A partially entered word is discarded, and the previously committed W_Addr/W_Data are cleared to 0.
- A button held through reset release yields one press DEBOUNCE_CYCLES + 2 cycles later (btn_db restarts at 0). That press is taken as the address.

**LED**
- LED is registered from the state and W_Addr and lags them by one cycle.

## Test plan

DEBOUNCE_CYCLES = 4 for all scenarios.

1. **Full load.** Reset, then 5 clean presses with SW = 8'h03, 78, 56, 34, 12. Required: exactly one Write_Reg pulse, with W_Addr = 5'd3 and W_Data = 32'h12345678 in that cycle; state returns to 0.
2. **Bounce rejection.** Toggle Load_BTN every 2 cycles for 20 cycles, then hold high for 10 cycles. Required: exactly one press, and the state advances 0→1 only.
3. **Latency.** Raise Load_BTN at cycle t. Required: press at t+6; with SW = 8'h1F in S_ADDR, the pending address is 31.
4. **Reset mid-word.** Enter the address plus 2 bytes, assert rst for 1 cycle, then do a full load with address 7 and bytes AA, BB, CC, DD. Required: no write before the final one; W_Data = 32'hDDCCBBAA, W_Addr = 7.
5. **Hold across reset.** Hold Load_BTN high through rst deassertion. Required: one press 6 cycles after release; state = 1.
6. **Back-to-back words.** Load 32'h00000001 to address 1, then 32'hFFFFFFFF to address 31. Required: two Write_Reg pulses with the correct pairs, and W_Data holds 1 between them.
